// File: rtl/button_debouncer.sv
// Counter-based push-button debouncer with press/release/auto-repeat pulse generation.
// Consumes an already-synchronized level; every output is registered.
module button_debouncer #(
   parameter int CNT_W           = 24,
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int REPEAT_DELAY    = 5000000,
   parameter int REPEAT_PERIOD   = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse,
   output logic key_event
);

   localparam logic [1:0] S_RELEASED    = 2'd0;
   localparam logic [1:0] S_PRESS_CHK   = 2'd1;
   localparam logic [1:0] S_PRESSED     = 2'd2;
   localparam logic [1:0] S_RELEASE_CHK = 2'd3;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_DLY  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RPT_PER  = CNT_W'(REPEAT_PERIOD);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam bit               DEB_ONE  = (DEBOUNCE_CYCLES == 1);
   localparam bit               RPT_EN   = (REPEAT_DELAY != 0);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_dcnt;
   logic [CNT_W-1:0] r_rcnt;
   logic             r_rpt_armed;
   logic             r_level;
   logic             r_press;
   logic             r_release;
   logic             r_repeat;
   logic             r_key;

   logic [CNT_W-1:0] w_dcnt_inc;
   logic [CNT_W-1:0] w_rcnt_inc;
   logic             w_deb_done;
   logic             w_rpt_hit;

   // Counters saturate rather than wrap.
   assign w_dcnt_inc = (&r_dcnt) ? r_dcnt : r_dcnt + ONE;
   assign w_rcnt_inc = (&r_rcnt) ? r_rcnt : r_rcnt + ONE;
   assign w_deb_done = (r_dcnt == DEB_LAST);
   // rcnt restarts at zero after every tick; the first tick waits DELAY, later ones PERIOD.
   assign w_rpt_hit  = RPT_EN && (w_rcnt_inc == (r_rpt_armed ? RPT_PER : RPT_DLY));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_RELEASED;
         r_dcnt      <= '0;
         r_rcnt      <= '0;
         r_rpt_armed <= 1'b0;
         r_level     <= 1'b0;
         r_press     <= 1'b0;
         r_release   <= 1'b0;
         r_repeat    <= 1'b0;
         r_key       <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_repeat  <= 1'b0;
         r_key     <= 1'b0;
         case (r_state)
            S_RELEASED: begin
               if (sync_in) begin
                  if (DEB_ONE) begin
                     r_state     <= S_PRESSED;
                     r_level     <= 1'b1;
                     r_press     <= 1'b1;
                     r_key       <= 1'b1;
                     r_rcnt      <= '0;
                     r_rpt_armed <= 1'b0;
                  end else begin
                     r_state <= S_PRESS_CHK;
                     r_dcnt  <= ONE;
                  end
               end
            end
            S_PRESS_CHK: begin
               if (!sync_in) begin
                  r_state <= S_RELEASED;
                  r_dcnt  <= '0;
               end else if (w_deb_done) begin
                  r_state     <= S_PRESSED;
                  r_dcnt      <= '0;
                  r_level     <= 1'b1;
                  r_press     <= 1'b1;
                  r_key       <= 1'b1;
                  r_rcnt      <= '0;
                  r_rpt_armed <= 1'b0;
               end else begin
                  r_dcnt <= w_dcnt_inc;
               end
            end
            S_PRESSED: begin
               if (!sync_in && DEB_ONE) begin
                  r_state     <= S_RELEASED;
                  r_level     <= 1'b0;
                  r_release   <= 1'b1;
                  r_rcnt      <= '0;
                  r_rpt_armed <= 1'b0;
               end else begin
                  // The hold timer keeps running on the edge that first sees a low sample.
                  if (w_rpt_hit) begin
                     r_rcnt      <= '0;
                     r_rpt_armed <= 1'b1;
                     r_repeat    <= 1'b1;
                     r_key       <= 1'b1;
                  end else begin
                     r_rcnt <= w_rcnt_inc;
                  end
                  if (!sync_in) begin
                     r_state <= S_RELEASE_CHK;
                     r_dcnt  <= ONE;
                  end
               end
            end
            S_RELEASE_CHK: begin
               if (sync_in) begin
                  r_state <= S_PRESSED;
                  r_dcnt  <= '0;
               end else if (w_deb_done) begin
                  r_state     <= S_RELEASED;
                  r_dcnt      <= '0;
                  r_level     <= 1'b0;
                  r_release   <= 1'b1;
                  r_rcnt      <= '0;
                  r_rpt_armed <= 1'b0;
               end else begin
                  r_dcnt <= w_dcnt_inc;
               end
            end
            default: begin
               r_state <= S_RELEASED;
               r_dcnt  <= '0;
               r_rcnt  <= '0;
               r_level <= 1'b0;
            end
         endcase
      end
   end

   assign btn_level     = r_level;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign repeat_pulse  = r_repeat;
   assign key_event     = r_key;

endmodule
